param_sync_fifo: RTL

Parametrised single-clock FIFO, the next-generation replacement for the fixed 8-bit synchronous FIFO in the PID datapath (sample buffering between the ADC front end and the controller core). Adds configurable width/depth, a fill-level count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, defined simultaneous read/write behaviour at full and empty, and an optional first-word-fall-through read mode.

---
 rtl/param_sync_fifo.sv | 125 ++++++++++++
 1 files changed

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with fill count, programmable
// almost-full/almost-empty thresholds and registered overflow/underflow pulses.
//
// Optional feature: define FIFO_FWFT_EN for first-word-fall-through reads
// (data_out_o shows the head word combinationally; 0 while empty). When it is
// undefined, data_out_o is a register loaded on every accepted read.
//
// Ports:
//   clk_i            clock, all state on rising edge
//   rst_i            synchronous active-high reset (priority over requests)
//   wr_cs_i/wr_en_i  write select/request; data_in_i is the write word
//   rd_cs_i/rd_en_i  read select/request; data_out_o is the read word
//   empty_o, full_o, almost_full_o, almost_empty_o, count_o  fill status
//   overflow_o       one-cycle pulse after a rejected write
//   underflow_o      one-cycle pulse after a rejected read
module param_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_cs_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  rd_cs_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH:0] DepthCnt = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AfCnt    = CW'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AeCnt    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic wr_req, rd_req, wr_acc, rd_acc;

    // Flags come only from the registered count.
    assign empty_o        = (count_q == '0);
    assign full_o         = (count_q == DepthCnt);
    assign almost_full_o  = (count_q >= AfCnt);
    assign almost_empty_o = (count_q <= AeCnt);
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    always_comb begin
        rd_req = rd_cs_i & rd_en_i;
        wr_req = wr_cs_i & wr_en_i;
        rd_acc = rd_req & ~empty_o;
        // At full a write only fits if a read frees a slot in the same cycle.
        wr_acc = wr_req & (~full_o | rd_acc);

        wr_ptr_d    = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        overflow_d  = wr_req & ~wr_acc;
        underflow_d = rd_req & ~rd_acc;

        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in_i;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out_o = empty_o ? '0 : mem_q[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] data_out_q;

    // Holds its value on idle cycles and rejected reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_out_q <= '0;
        end else if (rd_acc) begin
            data_out_q <= mem_q[rd_ptr_q];
        end
    end

    assign data_out_o = data_out_q;
`endif

endmodule
